// File: rtl/de_regfile_scoreboard.sv
// de_regfile_scoreboard: decode-stage integer register file (32x32) with
// per-register pending-writer counters that raise a stall on read-after-write
// and counter-overflow hazards. A sticky sb_err reports counter underflow or
// overflow.
// Optional feature: define WB_BYPASS_EN to forward the writeback value to the
// decode operands in the retire cycle and release the dependent stall then.
module de_regfile_scoreboard #(
  parameter int DBITS     = 32,
  parameter int REGNOBITS = 5,
  parameter int REGWORDS  = 32,
  parameter int CNTBITS   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wb_wr_reg,
  input  logic [REGNOBITS-1:0] wb_wregno,
  input  logic [DBITS-1:0]     wb_regval,
  input  logic [REGNOBITS-1:0] de_rs1,
  input  logic [REGNOBITS-1:0] de_rs2,
  input  logic                 de_use_rs1,
  input  logic                 de_use_rs2,
  input  logic                 de_issue,
  input  logic                 de_wr_reg,
  input  logic [REGNOBITS-1:0] de_rd,
  input  logic                 sq_valid,
  input  logic                 sq_wr_reg,
  input  logic [REGNOBITS-1:0] sq_rd,
  output logic [DBITS-1:0]     rs1_data,
  output logic [DBITS-1:0]     rs2_data,
  output logic                 stall,
  output logic                 sb_err
);

  // Counter arithmetic is done two bits wider and signed so that one
  // increment and two decrements can be summed before clamping.
  localparam int CW = CNTBITS + 2;
  localparam logic [CNTBITS-1:0] CNT_MAX = '1;

  logic [DBITS-1:0]   regfile_q [REGWORDS];
  logic [DBITS-1:0]   regfile_d [REGWORDS];
  logic [CNTBITS-1:0] pend_q    [REGWORDS];
  logic [CNTBITS-1:0] pend_d    [REGWORDS];
  logic               sb_err_q, sb_err_d;

  logic haz1, haz2, rd_full, inc_en;

  // Operand read; x0 is hard-wired to zero, optional same-cycle WB forwarding.
  always_comb begin
    rs1_data = (de_rs1 == '0) ? '0 : regfile_q[de_rs1];
    rs2_data = (de_rs2 == '0) ? '0 : regfile_q[de_rs2];
`ifdef WB_BYPASS_EN
    if (wb_wr_reg && wb_wregno == de_rs1 && de_rs1 != '0) rs1_data = wb_regval;
    if (wb_wr_reg && wb_wregno == de_rs2 && de_rs2 != '0) rs2_data = wb_regval;
`endif
  end

  // Hazard detection against the current counters only.
  always_comb begin
    haz1 = de_use_rs1 && de_rs1 != '0 && pend_q[de_rs1] != '0;
    haz2 = de_use_rs2 && de_rs2 != '0 && pend_q[de_rs2] != '0;
`ifdef WB_BYPASS_EN
    // The retiring writer is the last one pending: its value is forwarded.
    if (wb_wr_reg && wb_wregno == de_rs1 && pend_q[de_rs1] == CNTBITS'(1)) haz1 = 1'b0;
    if (wb_wr_reg && wb_wregno == de_rs2 && pend_q[de_rs2] == CNTBITS'(1)) haz2 = 1'b0;
`endif
    rd_full = de_wr_reg && de_rd != '0 && pend_q[de_rd] == CNT_MAX;
    stall   = de_issue && (haz1 || haz2 || rd_full);
    inc_en  = de_issue && !stall && de_wr_reg && de_rd != '0;
  end

  // Next-state for register file and pending counters; x0 never changes.
  always_comb begin
    regfile_d = regfile_q;
    pend_d    = pend_q;
    sb_err_d  = sb_err_q;
    if (wb_wr_reg && wb_wregno != '0) regfile_d[wb_wregno] = wb_regval;
    for (int r = 1; r < REGWORDS; r++) begin
      logic signed [CW-1:0] net;
      net = $signed({2'b00, pend_q[r]});
      if (inc_en && de_rd == REGNOBITS'(r))                 net = net + CW'(1);
      if (wb_wr_reg && wb_wregno == REGNOBITS'(r))          net = net - CW'(1);
      if (sq_valid && sq_wr_reg && sq_rd == REGNOBITS'(r))  net = net - CW'(1);
      if (net < 0) begin
        net      = '0;
        sb_err_d = 1'b1;
      end else if (net > $signed({2'b00, CNT_MAX})) begin
        net      = $signed({2'b00, CNT_MAX});
        sb_err_d = 1'b1;
      end
      pend_d[r] = net[CNTBITS-1:0];
    end
  end

  // State registers; reset discards all register and scoreboard state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regfile_q <= '{default: '0};
      pend_q    <= '{default: '0};
      sb_err_q  <= 1'b0;
    end else begin
      regfile_q <= regfile_d;
      pend_q    <= pend_d;
      sb_err_q  <= sb_err_d;
    end
  end

  assign sb_err = sb_err_q;

endmodule

// File: tb/tb_de_regfile_scoreboard.sv
// Self-checking bench for de_regfile_scoreboard: directed scenarios plus a
// randomized phase, all checked against an array/int reference model.
module tb_de_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_wr_reg;
  logic [4:0]  wb_wregno;
  logic [31:0] wb_regval;
  logic [4:0]  de_rs1, de_rs2;
  logic        de_use_rs1, de_use_rs2;
  logic        de_issue, de_wr_reg;
  logic [4:0]  de_rd;
  logic        sq_valid, sq_wr_reg;
  logic [4:0]  sq_rd;
  logic [31:0] rs1_data, rs2_data;
  logic        stall, sb_err;

  de_regfile_scoreboard dut (
    .clk(clk), .reset(reset),
    .wb_wr_reg(wb_wr_reg), .wb_wregno(wb_wregno), .wb_regval(wb_regval),
    .de_rs1(de_rs1), .de_rs2(de_rs2), .de_use_rs1(de_use_rs1), .de_use_rs2(de_use_rs2),
    .de_issue(de_issue), .de_wr_reg(de_wr_reg), .de_rd(de_rd),
    .sq_valid(sq_valid), .sq_wr_reg(sq_wr_reg), .sq_rd(sq_rd),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .stall(stall), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  // Reference model: architectural values, in-flight writer counts, error flag.
  logic [31:0] m_rf [32];
  int          m_pend [32];
  bit          m_err;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_rf[r]   = '0;
      m_pend[r] = 0;
    end
    m_err = 1'b0;
  endtask

  task automatic idle();
    wb_wr_reg = 0; wb_wregno = 0; wb_regval = 0;
    de_rs1 = 0; de_rs2 = 0; de_use_rs1 = 0; de_use_rs2 = 0;
    de_issue = 0; de_wr_reg = 0; de_rd = 0;
    sq_valid = 0; sq_wr_reg = 0; sq_rd = 0;
  endtask

  function automatic bit exp_haz(input bit use_it, input int rs);
    if (!use_it || rs == 0) return 1'b0;
`ifdef WB_BYPASS_EN
    if (wb_wr_reg && int'(wb_wregno) == rs && m_pend[rs] == 1) return 1'b0;
`endif
    return m_pend[rs] != 0;
  endfunction

  function automatic logic [31:0] exp_data(input int rs);
    if (rs == 0) return '0;
`ifdef WB_BYPASS_EN
    if (wb_wr_reg && int'(wb_wregno) == rs) return wb_regval;
`endif
    return m_rf[rs];
  endfunction

  // One clock cycle: inputs are already driven (called just after a negedge).
  // Checks outputs against the model, then advances the model across posedge.
  task automatic step(input string tag);
    bit es, acc;
    int n;
    #1;
    es = de_issue && (exp_haz(de_use_rs1, int'(de_rs1)) || exp_haz(de_use_rs2, int'(de_rs2)) ||
                      (de_wr_reg && de_rd != 0 && m_pend[de_rd] == 3));
    chk({tag, "_stall"}, 32'(stall), 32'(es));
    chk({tag, "_rs1"}, rs1_data, exp_data(int'(de_rs1)));
    chk({tag, "_rs2"}, rs2_data, exp_data(int'(de_rs2)));
    chk({tag, "_err"}, 32'(sb_err), 32'(m_err));
    acc = de_issue && !es && de_wr_reg && de_rd != 0;
    for (int r = 1; r < 32; r++) begin
      n = m_pend[r];
      if (acc && int'(de_rd) == r) n++;
      if (wb_wr_reg && int'(wb_wregno) == r) n--;
      if (sq_valid && sq_wr_reg && int'(sq_rd) == r) n--;
      if (n < 0) begin n = 0; m_err = 1'b1; end
      if (n > 3) begin n = 3; m_err = 1'b1; end
      m_pend[r] = n;
    end
    if (wb_wr_reg && wb_wregno != 0) m_rf[wb_wregno] = wb_regval;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue_wr(input logic [4:0] rd);
    de_issue = 1; de_wr_reg = 1; de_rd = rd;
  endtask

  task automatic retire(input logic [4:0] r, input logic [31:0] v);
    wb_wr_reg = 1; wb_wregno = r; wb_regval = v;
  endtask

  initial begin
    int r, q;
    idle();
    model_reset();
    reset = 1;
    #12;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_err", 32'(sb_err), 32'd0);
    @(negedge clk);
    reset = 0;

    // All registers read zero after reset.
    for (int i = 0; i < 32; i++) begin
      idle();
      de_rs1 = 5'(i); de_rs2 = 5'(31 - i); de_use_rs1 = 1; de_use_rs2 = 1;
      step("rst_read");
    end

    // Write x5 (legitimately in flight), read it back; x0 write ignored.
    idle(); issue_wr(5); step("iss5");
    idle(); retire(5, 32'hDEADBEEF); step("wb5");
    idle(); de_rs1 = 5; de_use_rs1 = 1; #1; chk("rd5", rs1_data, 32'hDEADBEEF); step("rd5");
    idle(); retire(0, 32'h1234); step("wb0");
    idle(); de_rs1 = 0; de_use_rs1 = 1; #1; chk("rd0", rs1_data, 32'h0); step("rd0");

    // RAW hazard on x7.
    idle(); issue_wr(7); step("c0");
    idle(); de_issue = 1; de_rs2 = 7; de_use_rs2 = 1; #1; chk("c1_stall", 32'(stall), 32'd1); step("c1");
    idle(); de_issue = 1; de_rs2 = 7; de_use_rs2 = 1; #1; chk("c2_stall", 32'(stall), 32'd1); step("c2");
    idle(); de_issue = 1; de_rs2 = 7; de_use_rs2 = 1; retire(7, 32'h55); #1;
`ifdef WB_BYPASS_EN
    chk("c3_stall", 32'(stall), 32'd0);
    chk("c3_data", rs2_data, 32'h55);
    step("c3");
`else
    chk("c3_stall", 32'(stall), 32'd1);
    step("c3");
    idle(); de_issue = 1; de_rs2 = 7; de_use_rs2 = 1; #1;
    chk("c4_stall", 32'(stall), 32'd0);
    chk("c4_data", rs2_data, 32'h55);
    step("c4");
`endif

    // Counter saturation on x9.
    for (int i = 0; i < 3; i++) begin
      idle(); issue_wr(9); #1; chk("iss9_ok", 32'(stall), 32'd0); step("iss9");
    end
    idle(); issue_wr(9); #1; chk("iss9_full", 32'(stall), 32'd1); step("iss9_full");
    idle(); issue_wr(9); retire(9, 32'h99); #1; chk("iss9_ret", 32'(stall), 32'd1); step("iss9_ret");
    idle(); issue_wr(9); #1; chk("iss9_go", 32'(stall), 32'd0); step("iss9_go");
    idle(); issue_wr(9); #1; chk("iss9_full2", 32'(stall), 32'd1); step("iss9_full2");
    for (int i = 0; i < 3; i++) begin
      idle(); retire(9, 32'(i)); step("drain9");
    end
    idle(); de_issue = 1; de_rs1 = 9; de_use_rs1 = 1; #1; chk("rd9_free", 32'(stall), 32'd0); step("rd9");

    // Same-cycle issue and retire on x4, then squash.
    idle(); issue_wr(4); step("iss4");
    idle(); issue_wr(4); retire(4, 32'h44); step("iss_ret4");
    idle(); de_issue = 1; de_rs1 = 4; de_use_rs1 = 1; #1; chk("x4_pend", 32'(stall), 32'd1); step("x4_chk");
    idle(); sq_valid = 1; sq_wr_reg = 1; sq_rd = 4; step("sq4");
    idle(); de_issue = 1; de_rs1 = 4; de_use_rs1 = 1; #1;
    chk("x4_free", 32'(stall), 32'd0);
    chk("x4_noerr", 32'(sb_err), 32'd0);
    step("x4_rd");

    // Randomized traffic on x0..x7, retires/squashes only of in-flight writers.
    for (int i = 0; i < 400; i++) begin
      idle();
      de_rs1 = 5'($urandom_range(0, 7)); de_rs2 = 5'($urandom_range(0, 7));
      de_use_rs1 = 1'($urandom_range(0, 1)); de_use_rs2 = 1'($urandom_range(0, 1));
      de_issue = 1'($urandom_range(0, 1)); de_wr_reg = 1'($urandom_range(0, 1));
      de_rd = 5'($urandom_range(0, 7));
      r = $urandom_range(1, 7);
      if (m_pend[r] > 0 && $urandom_range(0, 1) == 1) retire(5'(r), $urandom);
      q = $urandom_range(1, 7);
      if ($urandom_range(0, 4) == 0 &&
          m_pend[q] > ((wb_wr_reg && int'(wb_wregno) == q) ? 1 : 0)) begin
        sq_valid = 1; sq_wr_reg = 1; sq_rd = 5'(q);
      end
      step("rnd");
    end
    for (int k = 1; k < 8; k++) begin
      while (m_pend[k] > 0) begin
        idle(); retire(5'(k), $urandom); step("rnd_drain");
      end
    end

    // Retire with nothing pending: sticky error, counter stays zero.
    idle(); retire(12, 32'h12); step("ret12");
    idle(); #1; chk("err_set", 32'(sb_err), 32'd1); step("err_hold1");
    idle(); de_issue = 1; de_rs1 = 12; de_use_rs1 = 1; #1; chk("x12_zero", 32'(stall), 32'd0); step("err_hold2");
    idle(); #1; chk("err_sticky", 32'(sb_err), 32'd1);

    // Asynchronous reset mid-cycle clears everything immediately.
    idle(); issue_wr(3); de_rs1 = 5; de_use_rs1 = 1;
    #2 reset = 1;
    #1;
    chk("arst_err", 32'(sb_err), 32'd0);
    chk("arst_rs1", rs1_data, 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 0;
    idle(); de_rs1 = 5; de_use_rs1 = 1; step("post_rst");
    idle(); retire(5, 32'h77); step("post_rst_ret");
    idle(); #1; chk("post_rst_err", 32'(sb_err), 32'd1); step("post_rst_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
